// File: rtl/mb_cfg_loader_if.sv
// Bitstream word stream between the fabric source and the loader.
// Master drives word/valid, slave answers with ready.
interface mb_cfg_loader_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] data_in;
  logic              data_valid;
  logic              data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/mb_cfg_loader.sv
// Memory-bank configuration sequencer: packs a bit-line row from the
// word stream, then fires a timed one-hot word-line pulse per row.
module mb_cfg_loader #(
  parameter  int NUM_BL   = 315,
  parameter  int NUM_WL   = 4,
  parameter  int DATA_W   = 32,
  parameter  int WL_PULSE = 2,
  localparam int RW = (NUM_WL > 1) ? $clog2(NUM_WL) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  mb_cfg_loader_if.slave    bus,
  output logic [NUM_BL-1:0] bl_out,
  output logic [NUM_WL-1:0] wl_out,
  output logic [RW-1:0]     row_idx,
  output logic              busy,
  output logic              done
);
  localparam int WPR   = (NUM_BL + DATA_W - 1) / DATA_W;
  localparam int LASTW = NUM_BL - (WPR - 1) * DATA_W;
  localparam int CW    = $clog2(WPR + 1);
  localparam int PW    = $clog2(WL_PULSE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_FIN
  } state_t;

  state_t            r_state;
  logic [NUM_BL-1:0] r_bl;
  logic [NUM_WL-1:0] r_wl;
  logic [RW-1:0]     r_row;
  logic [CW-1:0]     r_wcnt;
  logic [PW-1:0]     r_pcnt;
  logic              r_busy;
  logic              r_done;
  logic              w_load;
  logic              w_hs;

  assign w_load         = (r_state == S_LOAD);
  assign w_hs           = w_load && bus.data_valid;
  assign bus.data_ready = w_load;

  assign bl_out  = r_bl;
  assign wl_out  = r_wl;
  assign row_idx = r_row;
  assign busy    = r_busy;
  assign done    = r_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_bl    <= '0;
      r_wl    <= '0;
      r_row   <= '0;
      r_wcnt  <= '0;
      r_pcnt  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_row   <= '0;
            r_wcnt  <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_hs) begin
            for (int k = 0; k < WPR - 1; k++) begin
              if (r_wcnt == CW'(k))
                r_bl[k*DATA_W +: DATA_W] <= bus.data_in;
            end
            // Final word only fills the ragged top of the row.
            if (r_wcnt == CW'(WPR - 1)) begin
              r_bl[NUM_BL-1 -: LASTW] <= bus.data_in[LASTW-1:0];
              r_state <= S_SETUP;
            end
            r_wcnt <= r_wcnt + 1'b1;
          end
        end
        S_SETUP: begin
          r_state <= S_PULSE;
          r_pcnt  <= '0;
          r_wl    <= {{(NUM_WL-1){1'b0}}, 1'b1} << r_row;
        end
        S_PULSE: begin
          if (r_pcnt == PW'(WL_PULSE - 1)) begin
            r_state <= S_HOLD;
            r_wl    <= '0;
          end else begin
            r_pcnt <= r_pcnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (r_row == RW'(NUM_WL - 1)) begin
            r_state <= S_FIN;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_LOAD;
            r_row   <= r_row + 1'b1;
            r_wcnt  <= '0;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mb_cfg_loader.sv
// Directed bench for mb_cfg_loader: table of full passes plus
// hand-written reset and abort sequences.
module tb_mb_cfg_loader;
  localparam int NUM_BL = 315;
  localparam int NUM_WL = 4;
  localparam int DATA_W = 32;
  localparam int WPR    = 10;

  typedef struct {
    int          gap;
    int          mode;
    logic [31:0] seed;
    int          exp_done;
    bit          poke;
  } pass_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [NUM_BL-1:0] bl_out;
  logic [NUM_WL-1:0] wl_out;
  logic [1:0]        row_idx;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  mb_cfg_loader_if #(.DATA_W(DATA_W)) bus ();

  mb_cfg_loader #(
    .NUM_BL(NUM_BL),
    .NUM_WL(NUM_WL),
    .DATA_W(DATA_W),
    .WL_PULSE(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .bus(bus),
    .bl_out(bl_out),
    .wl_out(wl_out),
    .row_idx(row_idx),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [319:0] got,
                     input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_bl"}, bl_out, '0);
    chk({nm, "_wl"}, wl_out, '0);
    chk({nm, "_row"}, row_idx, '0);
    chk({nm, "_busy"}, busy, '0);
    chk({nm, "_done"}, done, '0);
    chk({nm, "_ready"}, bus.data_ready, '0);
  endtask

  function automatic logic [31:0] word_of(pass_t p, int j);
    if (p.mode == 1)
      return ((j % WPR) == WPR - 1) ? 32'hFFFF_FFFF : 32'h0;
    return (p.seed * 32'(j + 1)) ^ 32'(j << 8);
  endfunction

  task automatic send_word(input logic [31:0] w, input int gap);
    int n;
    bus.data_in    = w;
    bus.data_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.data_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout got 0 want 1 at %0t", $time);
    end
    @(posedge clk);
    #1;
    if (gap > 0) begin
      bus.data_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic run_pass(input pass_t p);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    fork
      begin
        for (int j = 0; j < NUM_WL * WPR; j++)
          send_word(word_of(p, j), p.gap);
        bus.data_valid = 1'b0;
      end
      begin
        int n, row, wc, ph;
        bit fin;
        logic [319:0] acc;
        n = 0; row = 0; wc = 0; ph = 0; fin = 1'b0; acc = '0;
        while (!fin) begin
          @(negedge clk);
          n++;
          if (n > 600) begin
            chk("pass_timeout", 320'(n), 320'(p.exp_done));
            break;
          end
          if (ph == 0) begin
            chk("ready_load", bus.data_ready, 1);
            chk("wl_load", wl_out, 0);
            if (bus.data_valid && bus.data_ready) begin
              acc[wc*32 +: 32] = bus.data_in;
              wc++;
              if (wc == WPR) ph = 1;
            end
          end else begin
            chk("wl_row", wl_out,
                (ph == 2 || ph == 3) ? (320'd1 << row) : 320'd0);
            chk("bl_row", bl_out, {5'b0, acc[NUM_BL-1:0]});
            chk("ready_off", bus.data_ready, 0);
            chk("row_idx", row_idx, 320'(row));
            chk("busy_row", busy, 1);
            start = (p.poke && row == 1 && ph == 2);
            if (ph == 4) begin
              ph = 0; wc = 0; row++;
              if (row == NUM_WL) fin = 1'b1;
            end else begin
              ph++;
            end
          end
          if (!fin) chk("done_early", done, 0);
        end
        @(negedge clk);
        n++;
        chk("done_pulse", done, 1);
        chk("done_cycle", 320'(n), 320'(p.exp_done));
        chk("busy_fin", busy, 1);
        start = p.poke;
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
          chk("done_after", done, 0);
          chk("busy_after", busy, 0);
          chk("wl_after", wl_out, 0);
          chk("ready_after", bus.data_ready, 0);
          @(negedge clk);
        end
      end
    join
  endtask

  initial begin
    pass_t tbl[4];
    logic [NUM_BL-1:0] trunc;
    tbl[0] = '{gap: 0, mode: 0, seed: 32'h1234_5678, exp_done: 57,  poke: 0};
    tbl[1] = '{gap: 5, mode: 0, seed: 32'hA5A5_0F0F, exp_done: 240, poke: 0};
    tbl[2] = '{gap: 2, mode: 1, seed: 32'h0,         exp_done: 129, poke: 0};
    tbl[3] = '{gap: 0, mode: 0, seed: 32'hDEAD_BEEF, exp_done: 57,  poke: 1};
    trunc = {{27{1'b1}}, 288'b0};

    bus.data_in    = 32'hFFFF_FFFF;
    bus.data_valid = 1'b1;
    start          = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_idle("rst_hold");
    reset          = 1'b1;
    start          = 1'b0;
    bus.data_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("rst_rel");

    for (int i = 0; i < 4; i++) begin
      run_pass(tbl[i]);
      if (tbl[i].mode == 1)
        chk("trunc_bl", bl_out, {5'b0, trunc});
    end

    // Abort during the row-2 word-line pulse.
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    bus.data_in    = 32'h0F0F_3C3C;
    bus.data_valid = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_pre_wl", wl_out, 4'b0100);
    #2 reset = 1'b0;
    #1;
    chk("abort_wl", wl_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_bl", bl_out, 0);
    chk("abort_ready", bus.data_ready, 0);
    bus.data_valid = 1'b0;
    #3 reset = 1'b1;
    run_pass(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mb_cfg_loader.md
Name: mb_cfg_loader

Overview:
- Memory-bank configuration sequencer for one FPGA tile.
- Takes the tile bitstream as a valid/ready word stream and assembles one full bit-line (BL) row per word-line.
- Drives BL, then a timed one-hot word-line (WL) pulse, for every WL row in turn.
- Sits between the fabric-level bitstream source and the tile's bl_in/wl_in configuration ports.

Parameters:
- NUM_BL, 315, bit-lines per row (tile bl_in width)
- NUM_WL, 4, word-lines (tile wl_in width)
- DATA_W, 32, bitstream word width
- WL_PULSE, 2, WL high time in cycles (>=1)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a full configuration pass
- data_in  input  DATA_W  bitstream word
- data_valid  input  1  data_in valid
- data_ready  output  1  loader accepts data_in this cycle
- bl_out  output  NUM_BL  bit-line drive to tile bl_in
- wl_out  output  NUM_WL  one-hot word-line drive to tile wl_in
- row_idx  output  clog2(NUM_WL)  current row
- busy  output  1  pass in progress
- done  output  1  one-cycle pulse at end of pass

Behaviour:
- Reset (reset low, asynchronous): state IDLE; bl_out=0, wl_out=0, row_idx=0, busy=0, done=0, data_ready=0, word counter=0.
- WPR = ceil(NUM_BL/DATA_W) words per row (10 at defaults).
- Word k of a row maps data_in[i] -> bl[k*DATA_W+i].
- On the final word, only the low NUM_BL-(WPR-1)*DATA_W bits are used (27 at defaults); the upper bits are discarded.
- FSM states: IDLE, LOAD, SETUP, PULSE, HOLD, FIN.
  - IDLE: start=1 -> LOAD, row_idx=0, busy=1. start in any other state is ignored.
  - LOAD: data_ready=1 (combinational from state). Each valid&ready handshake writes one word and increments the word counter. The handshake of word WPR-1 -> SETUP next cycle. data_valid gaps stall with no timeout.
  - SETUP: 1 cycle; bl_out stable, wl_out=0.
  - PULSE: wl_out = 1<<row_idx for exactly WL_PULSE cycles; bl_out held.
  - HOLD: 1 cycle; wl_out=0, bl_out held. If row_idx==NUM_WL-1 -> FIN; else row_idx+1, word counter=0 -> LOAD.
  - FIN: done=1 for one cycle, busy=0 from the next cycle, -> IDLE.
- data_ready=0 outside LOAD; data_valid is ignored there and no word is consumed.
- bl_out updates only during LOAD; it keeps its last row value after the pass (not cleared).
- wl_out is never high outside PULSE and never has more than one bit set.
- Minimum cycles per row: WPR+1+WL_PULSE+1 (14 at defaults). Full pass: 56 cycles, then the FIN cycle.
- Reset mid-pass: immediate return to the reset values above; the pass is abandoned and the next start restarts from row 0.
- start coincident with FIN: ignored. A new pass needs start while in IDLE.

Test Plan:
- Reset values: hold reset low, toggle clk, drive start/data_valid=1 -> all outputs 0, state IDLE; release reset, no start -> outputs stay 0.
- Full pass, defaults: start, then 40 words with data_valid held high -> wl_out sequence 0001,0010,0100,1000, each high for 2 cycles; done pulses 57 cycles after start; bl_out matches the packed row each time WL is high.
- Last-word truncation: final row word = 32'hFFFF_FFFF, prior words 0 -> bl_out[314:288]=all ones, bl_out[287:0]=0; no bit beyond 314 is affected.
- Backpressure/gaps: deassert data_valid 5 cycles between every word -> data_ready stays high through LOAD; WL timing per row is unchanged after the last word; word count per row is exactly 10.
- Ignored start and idle data: pulse start during PULSE of row 1 and drive data_valid during SETUP/PULSE/HOLD -> no restart, no word consumed, pass completes with the correct data.
- Reset mid-PULSE of row 2 -> wl_out=0 asynchronously, busy=0; a new start reloads from row 0 with wl_out=0001 first.
